// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES plaintext front end.
// Holds the native block size, packer state encoding and PKCS#7 pad helper.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic {
        FILL,
        PAD_BLK
    } state_e;

    // Pad value when the last data byte sits at idx.
    function automatic logic [7:0] pkcs7_fill(input int block_bytes,
                                              input int idx);
        return 8'(block_bytes - 1 - idx);
    endfunction

endpackage

// File: rtl/block_fifo.sv
// Generic first-word-first-out queue of fixed-width entries.
// Head entry is presented directly on rd_data; reset clears all entries.
module block_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_wr, do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    assign full    = (cnt_q == CNT_MAX);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_wr && !do_rd) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (do_rd && !do_wr) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/plain_text_packer.sv
// Packs a plaintext byte stream into cipher-width blocks with optional
// PKCS#7 padding and queues finished blocks for the AES core.
module plain_text_packer
    import aes_pkg::*;
#(
    parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
    parameter int DEPTH       = 2,
    parameter bit PAD_EN      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [8*BLOCK_BYTES-1:0] out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [31:0]              blk_cnt
);

    localparam int IW = $clog2(BLOCK_BYTES);
    localparam int DW = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(BLOCK_BYTES - 1);
    localparam logic [7:0]    FULL_PAD = 8'(BLOCK_BYTES);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] asm_q, asm_d;
    logic [31:0]   blk_cnt_q;

    logic          fifo_full, fifo_empty;
    logic          push, pop, accept, at_end;
    logic [DW:0]   push_entry, head;
    logic [CW-1:0] fifo_cnt;
    logic          unused_cnt;

    assign in_ready   = (state_q == FILL) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign at_end     = (idx_q == IDX_MAX);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign out_data   = head[DW-1:0];
    assign out_last   = head[DW];
    assign blk_cnt    = blk_cnt_q;
    assign unused_cnt = ^fifo_cnt;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        push       = 1'b0;
        push_entry = {1'b0, asm_q};
        if (state_q == PAD_BLK) begin
            if (!fifo_full) begin
                push       = 1'b1;
                push_entry = {1'b1, {BLOCK_BYTES{FULL_PAD}}};
                state_d    = FILL;
            end
        end else if (accept) begin
            asm_d[8*idx_q +: 8] = in_data;
            if (in_last) begin
                for (int k = 0; k < BLOCK_BYTES; k++) begin
                    if (k > int'(idx_q)) begin
                        asm_d[8*k +: 8] = PAD_EN
                            ? pkcs7_fill(BLOCK_BYTES, int'(idx_q))
                            : 8'h00;
                    end
                end
            end
            push = in_last || at_end;
            // A full final block under PKCS#7 still owes a whole pad block.
            push_entry = {in_last && !(PAD_EN && at_end), asm_d};
            if (in_last && PAD_EN && at_end) begin
                state_d = PAD_BLK;
            end
            idx_d = in_last ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            idx_q     <= '0;
            asm_q     <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            if (pop) begin
                blk_cnt_q <= blk_cnt_q + 32'd1;
            end
        end
    end

    block_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

endmodule

// File: tb/tb_plain_text_packer.sv
// Directed scoreboard bench for plain_text_packer: zero-fill, PKCS#7,
// backpressure, mid-stream reset and an 8-byte block variant.
module tb_plain_text_packer;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        vin = 1'b0;
    logic        lin = 1'b0;
    logic        ordy = 1'b0;
    int          sel = 0;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    logic         rdy0, rdy1, rdy2;
    logic         val0, val1, val2;
    logic         lst0, lst1, lst2;
    logic [127:0] dat0, dat1;
    logic [63:0]  dat2;
    logic [31:0]  cnt0, cnt1, cnt2;

    logic         obs_rdy, obs_val, obs_lst;
    logic [127:0] obs_dat;
    logic [31:0]  obs_cnt;

    always #5 clk = ~clk;

    plain_text_packer #(.BLOCK_BYTES(16), .DEPTH(2), .PAD_EN(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(din),
        .in_valid(vin && sel == 0), .in_last(lin), .in_ready(rdy0),
        .out_data(dat0), .out_valid(val0), .out_last(lst0),
        .out_ready(ordy && sel == 0), .blk_cnt(cnt0));

    plain_text_packer #(.BLOCK_BYTES(16), .DEPTH(2), .PAD_EN(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(din),
        .in_valid(vin && sel == 1), .in_last(lin), .in_ready(rdy1),
        .out_data(dat1), .out_valid(val1), .out_last(lst1),
        .out_ready(ordy && sel == 1), .blk_cnt(cnt1));

    plain_text_packer #(.BLOCK_BYTES(8), .DEPTH(2), .PAD_EN(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(din),
        .in_valid(vin && sel == 2), .in_last(lin), .in_ready(rdy2),
        .out_data(dat2), .out_valid(val2), .out_last(lst2),
        .out_ready(ordy && sel == 2), .blk_cnt(cnt2));

    always_comb begin
        obs_rdy = rdy0;
        obs_val = val0;
        obs_lst = lst0;
        obs_dat = dat0;
        obs_cnt = cnt0;
        if (sel == 1) begin
            obs_rdy = rdy1;
            obs_val = val1;
            obs_lst = lst1;
            obs_dat = dat1;
            obs_cnt = cnt1;
        end else if (sel == 2) begin
            obs_rdy = rdy2;
            obs_val = val2;
            obs_lst = lst2;
            obs_dat = {64'h0, dat2};
            obs_cnt = cnt2;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: a pop happens on the edge after a valid&&ready sample.
    always @(negedge clk) begin
        if (rst_n && obs_val && ordy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_block", obs_dat, 128'hx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", obs_dat, e.data);
                chk("out_last", {127'h0, obs_lst}, {127'h0, e.last});
            end
        end
    end

    task automatic push_exp(input logic [127:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        din = d;
        lin = l;
        vin = 1'b1;
        @(negedge clk);
        while (!obs_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("send_timeout", 128'(n), 128'(0));
        end
        @(posedge clk);
        #1;
        vin = 1'b0;
        lin = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] blk;

        // Reset state
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_in_ready", {127'h0, obs_rdy}, 128'h1);
            chk("rst_out_valid", {127'h0, obs_val}, 128'h0);
            chk("rst_out_last", {127'h0, obs_lst}, 128'h0);
            chk("rst_out_data", obs_dat, 128'h0);
            chk("rst_blk_cnt", {96'h0, obs_cnt}, 128'h0);
        end
        sel = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero-fill, exact 16-byte message
        ordy = 1'b1;
        push_exp(128'h0F0E0D0C0B0A09080706050403020100, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(8'(i), i == 15);
        end
        chk("latency_valid", {127'h0, obs_val}, 128'h1);
        drain();
        chk("blk_cnt_t1", {96'h0, obs_cnt}, 128'd1);

        // PKCS#7 short message
        sel = 1;
        push_exp(128'h0B0B0B0B0B0B0B0B0B0B0B6564636261, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h61 + i), i == 4);
        end
        drain();

        // PKCS#7 full block -> extra pad block
        do_reset();
        push_exp(128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
        push_exp({16{8'h10}}, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(8'(i), i == 15);
        end
        chk("pad_blk_ready_lo", {127'h0, obs_rdy}, 128'h0);
        @(posedge clk);
        #1;
        chk("pad_blk_ready_hi", {127'h0, obs_rdy}, 128'h1);
        drain();
        chk("blk_cnt_t3", {96'h0, obs_cnt}, 128'd2);

        // Backpressure with a full FIFO
        sel = 0;
        do_reset();
        ordy = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 16; k++) begin
                blk[8*k +: 8] = 8'(16 * b + k);
            end
            push_exp(blk, b == 2);
        end
        for (int i = 0; i < 32; i++) begin
            send(8'(i), 1'b0);
        end
        chk("full_ready_lo", {127'h0, obs_rdy}, 128'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_ready_hold", {127'h0, obs_rdy}, 128'h0);
        chk("stall_data", obs_dat, exp_q[0].data);
        chk("stall_last", {127'h0, obs_lst}, 128'h0);
        ordy = 1'b1;
        for (int i = 32; i < 48; i++) begin
            send(8'(i), i == 47);
        end
        drain();
        chk("blk_cnt_t4", {96'h0, obs_cnt}, 128'd3);

        // Mid-stream asynchronous reset
        do_reset();
        ordy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(8'h55, 1'b0);
        end
        for (int i = 0; i < 7; i++) begin
            send(8'(8'h30 + i), 1'b0);
        end
        chk("pre_rst_valid", {127'h0, obs_val}, 128'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {127'h0, obs_val}, 128'h0);
        chk("async_rst_ready", {127'h0, obs_rdy}, 128'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy = 1'b1;
        push_exp(128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(8'(8'hA0 + i), i == 15);
        end
        drain();
        chk("blk_cnt_t5", {96'h0, obs_cnt}, 128'd1);

        // 8-byte block, single byte with PKCS#7
        sel = 2;
        push_exp(128'h0707070707070742, 1'b1);
        send(8'h42, 1'b1);
        drain();
        chk("blk_cnt_t6", {96'h0, obs_cnt}, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
